// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I decode definitions: base opcode values,
//                immediate format enumeration, canonical NOP encoding and
//                small opcode classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // Base RV32I major opcodes (iw[6:0])
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_IW = 32'h00000013;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_fmt_t;

    // Opcode to immediate format. Unknown opcodes carry no immediate.
    function automatic imm_fmt_t imm_fmt(input logic [6:0] opc);
        imm_fmt_t fmt;
        case (opc)
            LUI, AUIPC:                          fmt = IMM_U;
            JAL:                                 fmt = IMM_J;
            JALR, LOAD, OP_IMM, MISC_MEM, SYSTEM: fmt = IMM_I;
            BRANCH:                              fmt = IMM_B;
            STORE:                               fmt = IMM_S;
            default:                             fmt = IMM_R;
        endcase
        return fmt;
    endfunction

    // True for any opcode belonging to the RV32I base set.
    function automatic logic opc_legal(input logic [6:0] opc);
        logic ok;
        case (opc)
            LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE,
            OP_IMM, OP, MISC_MEM, SYSTEM: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/rv32i_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_imm_gen
//  Description : Combinational RV32I immediate generator. Decodes the
//                immediate format from the opcode and assembles the
//                sign-extended immediate (B/J have bit0 = 0, U has the
//                low 12 bits clear, R-type and unknown opcodes give 0).
//  Ports       : iw_i  [31:0]     instruction word
//                imm_o [XLEN-1:0] sign-extended immediate
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     iw_i,
    output logic [XLEN-1:0] imm_o
);

    imm_fmt_t    w_fmt;
    logic [31:0] w_imm32;

    assign w_fmt = imm_fmt(iw_i[6:0]);

    always_comb begin
        w_imm32 = 32'h0;
        case (w_fmt)
            IMM_I:   w_imm32 = {{20{iw_i[31]}}, iw_i[31:20]};
            IMM_S:   w_imm32 = {{20{iw_i[31]}}, iw_i[31:25], iw_i[11:7]};
            IMM_B:   w_imm32 = {{19{iw_i[31]}}, iw_i[31], iw_i[7],
                                iw_i[30:25], iw_i[11:8], 1'b0};
            IMM_U:   w_imm32 = {iw_i[31:12], 12'h000};
            IMM_J:   w_imm32 = {{11{iw_i[31]}}, iw_i[31], iw_i[19:12],
                                iw_i[20], iw_i[30:21], 1'b0};
            default: w_imm32 = 32'h0;
        endcase
    end

    // Bit 31 of the 32-bit immediate already equals the sign (or 0 for
    // R-type), so widening simply replicates it up to XLEN.
    assign imm_o = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

endmodule : rv32i_imm_gen
`default_nettype wire

// File: rtl/rv32i_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_id_stage
//  Description : RV32I instruction decode stage with valid/ready handshake,
//                flush, write-back-enable decode, immediate generation and
//                RAW hazard detection against NUM_HAZ_STAGES in-flight
//                destinations (index 0 = youngest, EX).
//  Build macro : RV32I_ID_FORWARDING_EN - when defined, the youngest matching
//                stage with haz_fwd_ok set bypasses its result into the
//                operand instead of stalling. When undefined, haz_fwd_ok and
//                haz_wb_data are ignored and any match stalls.
//  Ports       : clk, reset (async, active-low)
//                in_valid/in_ready, iw_in, pc_in        - fetch side
//                rs1_reg/rs2_reg, rs1_data/rs2_data     - register file
//                haz_wb_en/haz_wb_reg/haz_fwd_ok/haz_wb_data - downstream
//                flush                                  - kill held+incoming
//                out_valid/out_ready, iw_out, pc_out, rs1_data_out,
//                rs2_data_out, imm_out, wb_reg_out, wb_en_out, illegal_out
//                                                       - execute side
//                stall_out                              - hazard stall
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_id_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_HAZ_STAGES = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      iw_in,
    input  logic [XLEN-1:0]                  pc_in,
    output logic [4:0]                       rs1_reg,
    output logic [4:0]                       rs2_reg,
    input  logic [XLEN-1:0]                  rs1_data,
    input  logic [XLEN-1:0]                  rs2_data,
    input  logic [NUM_HAZ_STAGES-1:0]        haz_wb_en,
    input  logic [5*NUM_HAZ_STAGES-1:0]      haz_wb_reg,
    input  logic [NUM_HAZ_STAGES-1:0]        haz_fwd_ok,
    input  logic [XLEN*NUM_HAZ_STAGES-1:0]   haz_wb_data,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      iw_out,
    output logic [XLEN-1:0]                  pc_out,
    output logic [XLEN-1:0]                  rs1_data_out,
    output logic [XLEN-1:0]                  rs2_data_out,
    output logic [XLEN-1:0]                  imm_out,
    output logic [4:0]                       wb_reg_out,
    output logic                             wb_en_out,
    output logic                             illegal_out,
    output logic                             stall_out
);

    localparam logic [4:0] c_X0 = 5'd0;

    // ------------------------------------------------------------------
    // Field extraction and opcode classification
    // ------------------------------------------------------------------
    logic [6:0]      w_opc;
    logic [4:0]      w_rd;
    logic            w_legal;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_wb_en;
    logic [XLEN-1:0] w_imm;

    assign w_opc   = iw_in[6:0];
    assign w_rd    = iw_in[11:7];
    assign rs1_reg = iw_in[19:15];
    assign rs2_reg = iw_in[24:20];
    assign w_legal = opc_legal(w_opc);

    always_comb begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b0;
        case (w_opc)
            LUI, AUIPC, JAL:   w_use_rs1 = 1'b0;
            OP, STORE, BRANCH: w_use_rs2 = 1'b1;
            default:           ;
        endcase
    end

    assign w_wb_en = w_legal && (w_opc != STORE) && (w_opc != BRANCH)
                     && (w_rd != c_X0);

    rv32i_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .iw_i  (iw_in),
        .imm_o (w_imm)
    );

    // ------------------------------------------------------------------
    // Per-stage RAW match. x0 never creates a dependency.
    // ------------------------------------------------------------------
    logic [NUM_HAZ_STAGES-1:0] w_match_rs1;
    logic [NUM_HAZ_STAGES-1:0] w_match_rs2;

    generate
        for (genvar gi = 0; gi < NUM_HAZ_STAGES; gi++) begin : g_haz
            assign w_match_rs1[gi] = w_use_rs1 && (rs1_reg != c_X0) &&
                                     haz_wb_en[gi] &&
                                     (haz_wb_reg[5*gi +: 5] == rs1_reg);
            assign w_match_rs2[gi] = w_use_rs2 && (rs2_reg != c_X0) &&
                                     haz_wb_en[gi] &&
                                     (haz_wb_reg[5*gi +: 5] == rs2_reg);
        end
    endgenerate

    logic            w_stall_rs1;
    logic            w_stall_rs2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

`ifdef RV32I_ID_FORWARDING_EN
    // Walk from oldest to youngest so the youngest match is the one that
    // sticks; an older stage holds a stale value for the same register.
    always_comb begin
        w_stall_rs1 = 1'b0;
        w_stall_rs2 = 1'b0;
        w_rs1_val   = rs1_data;
        w_rs2_val   = rs2_data;
        for (int i = NUM_HAZ_STAGES - 1; i >= 0; i--) begin
            if (w_match_rs1[i]) begin
                w_stall_rs1 = ~haz_fwd_ok[i];
                w_rs1_val   = haz_wb_data[XLEN*i +: XLEN];
            end
            if (w_match_rs2[i]) begin
                w_stall_rs2 = ~haz_fwd_ok[i];
                w_rs2_val   = haz_wb_data[XLEN*i +: XLEN];
            end
        end
    end
`else
    logic w_unused_fwd;

    assign w_stall_rs1  = |w_match_rs1;
    assign w_stall_rs2  = |w_match_rs2;
    assign w_rs1_val    = rs1_data;
    assign w_rs2_val    = rs2_data;
    assign w_unused_fwd = ^{haz_fwd_ok, haz_wb_data};
`endif

    // ------------------------------------------------------------------
    // Handshake. Flush always accepts so the incoming word is consumed.
    // ------------------------------------------------------------------
    logic valid_q;
    logic valid_d;
    logic w_capture;

    assign stall_out = in_valid & (w_stall_rs1 | w_stall_rs2);
    assign in_ready  = flush | (~stall_out & (~valid_q | out_ready));
    assign w_capture = in_valid & in_ready & ~flush;

    // ------------------------------------------------------------------
    // Output bundle registers
    // ------------------------------------------------------------------
    logic [31:0]     iw_q,      iw_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] rs1_q,     rs1_d;
    logic [XLEN-1:0] rs2_q,     rs2_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    logic [4:0]      rd_q,      rd_d;
    logic            wb_en_q,   wb_en_d;
    logic            illegal_q, illegal_d;

    always_comb begin
        valid_d   = valid_q;
        iw_d      = iw_q;
        pc_d      = pc_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        wb_en_d   = wb_en_q;
        illegal_d = illegal_q;
        if (flush) begin
            // Killed bundle must not be able to retire a write.
            valid_d = 1'b0;
            wb_en_d = 1'b0;
        end else if (w_capture) begin
            valid_d   = 1'b1;
            iw_d      = iw_in;
            pc_d      = pc_in;
            rs1_d     = w_rs1_val;
            rs2_d     = w_rs2_val;
            imm_d     = w_imm;
            rd_d      = w_rd;
            wb_en_d   = w_wb_en;
            illegal_d = ~w_legal;
        end else if (valid_q && out_ready) begin
            // Drained with nothing behind it: bubble.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            iw_q      <= NOP_IW;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            rd_q      <= 5'd0;
            wb_en_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            iw_q      <= iw_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            wb_en_q   <= wb_en_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid    = valid_q;
    assign iw_out       = iw_q;
    assign pc_out       = pc_q;
    assign rs1_data_out = rs1_q;
    assign rs2_data_out = rs2_q;
    assign imm_out      = imm_q;
    assign wb_reg_out   = rd_q;
    assign wb_en_out    = wb_en_q;
    assign illegal_out  = illegal_q;

endmodule : rv32i_id_stage
`default_nettype wire

// File: tb/tb_rv32i_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_id_stage
//  Description : Self-checking bench for rv32i_id_stage. A behavioural model
//                derives the decoded bundle, hazard stall and handshake from
//                the RV32I rules; a compare process checks every output on
//                every falling edge, and directed cases pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_id_stage;

    localparam int N = 3;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   iw_in;
    logic [31:0]   pc_in;
    logic [4:0]    rs1_reg;
    logic [4:0]    rs2_reg;
    logic [31:0]   rs1_data;
    logic [31:0]   rs2_data;
    logic [N-1:0]  haz_wb_en;
    logic [5*N-1:0] haz_wb_reg;
    logic [N-1:0]  haz_fwd_ok;
    logic [32*N-1:0] haz_wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   iw_out;
    logic [31:0]   pc_out;
    logic [31:0]   rs1_data_out;
    logic [31:0]   rs2_data_out;
    logic [31:0]   imm_out;
    logic [4:0]    wb_reg_out;
    logic          wb_en_out;
    logic          illegal_out;
    logic          stall_out;

    always #5 clk = ~clk;

    rv32i_id_stage #(.XLEN(32), .NUM_HAZ_STAGES(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .iw_in        (iw_in),
        .pc_in        (pc_in),
        .rs1_reg      (rs1_reg),
        .rs2_reg      (rs2_reg),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .haz_wb_en    (haz_wb_en),
        .haz_wb_reg   (haz_wb_reg),
        .haz_fwd_ok   (haz_fwd_ok),
        .haz_wb_data  (haz_wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .iw_out       (iw_out),
        .pc_out       (pc_out),
        .rs1_data_out (rs1_data_out),
        .rs2_data_out (rs2_data_out),
        .imm_out      (imm_out),
        .wb_reg_out   (wb_reg_out),
        .wb_en_out    (wb_en_out),
        .illegal_out  (illegal_out),
        .stall_out    (stall_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference rules
    // ------------------------------------------------------------------
    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                         7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] iw);
        longint v;
        v = 0;
        case (iw[6:0])
            7'h37, 7'h17: return iw & 32'hFFFFF000;
            7'h6F: begin
                v = {iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
                if (v >= (1 << 20)) v = v - (1 << 21);
            end
            7'h63: begin
                v = {iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
                if (v >= 4096) v = v - 8192;
            end
            7'h23: begin
                v = {iw[31:25], iw[11:7]};
                if (v >= 2048) v = v - 4096;
            end
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin
                v = iw[31:20];
                if (v >= 2048) v = v - 4096;
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    // {stall, operand value} for one source register
    function automatic logic [32:0] resolve(input logic [4:0] r, input bit used,
                                            input logic [31:0] rf);
        if (!used || r == 5'd0) return {1'b0, rf};
        for (int i = 0; i < N; i++) begin
            if (haz_wb_en[i] && haz_wb_reg[5*i +: 5] == r) begin
`ifdef RV32I_ID_FORWARDING_EN
                if (haz_fwd_ok[i]) return {1'b0, haz_wb_data[32*i +: 32]};
`endif
                return {1'b1, rf};
            end
        end
        return {1'b0, rf};
    endfunction

    // ------------------------------------------------------------------
    // Model state and combinational expectations
    // ------------------------------------------------------------------
    logic        m_valid, m_wben, m_ill;
    logic [31:0] m_iw, m_pc, m_rs1, m_rs2, m_imm;
    logic [4:0]  m_rd;

    logic [32:0] e_r1, e_r2;
    logic        e_stall, e_ready, e_wben;
    bit          e_use1, e_use2;

    always_comb begin
        e_use1  = !(iw_in[6:0] inside {7'h37, 7'h17, 7'h6F});
        e_use2  = iw_in[6:0] inside {7'h33, 7'h23, 7'h63};
        e_r1    = resolve(iw_in[19:15], e_use1, rs1_data);
        e_r2    = resolve(iw_in[24:20], e_use2, rs2_data);
        e_stall = in_valid && (e_r1[32] || e_r2[32]);
        e_ready = flush || (!e_stall && (!m_valid || out_ready));
        e_wben  = is_legal(iw_in[6:0]) && iw_in[6:0] != 7'h23 &&
                  iw_in[6:0] != 7'h63 && iw_in[11:7] != 5'd0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0; m_iw <= NOP; m_pc <= 32'h0; m_rs1 <= 32'h0;
            m_rs2 <= 32'h0; m_imm <= 32'h0; m_rd <= 5'd0; m_wben <= 1'b0;
            m_ill <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_wben  <= 1'b0;
        end else if (in_valid && e_ready) begin
            m_valid <= 1'b1;
            m_iw    <= iw_in;
            m_pc    <= pc_in;
            m_rs1   <= e_r1[31:0];
            m_rs2   <= e_r2[31:0];
            m_imm   <= ref_imm(iw_in);
            m_rd    <= iw_in[11:7];
            m_wben  <= e_wben;
            m_ill   <= !is_legal(iw_in[6:0]);
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("out_valid",    {31'h0, out_valid},   {31'h0, m_valid});
        chk("iw_out",       iw_out,               m_iw);
        chk("pc_out",       pc_out,               m_pc);
        chk("rs1_data_out", rs1_data_out,         m_rs1);
        chk("rs2_data_out", rs2_data_out,         m_rs2);
        chk("imm_out",      imm_out,              m_imm);
        chk("wb_reg_out",   {27'h0, wb_reg_out},  {27'h0, m_rd});
        chk("wb_en_out",    {31'h0, wb_en_out},   {31'h0, m_wben});
        chk("illegal_out",  {31'h0, illegal_out}, {31'h0, m_ill});
        chk("stall_out",    {31'h0, stall_out},   {31'h0, e_stall});
        chk("in_ready",     {31'h0, in_ready},    {31'h0, e_ready});
        chk("rs1_reg",      {27'h0, rs1_reg},     {27'h0, iw_in[19:15]});
        chk("rs2_reg",      {27'h0, rs2_reg},     {27'h0, iw_in[24:20]});
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] iw, input logic [31:0] pc);
        in_valid = v;
        iw_in    = iw;
        pc_in    = pc;
        rs1_data = $urandom;
        rs2_data = $urandom;
    endtask

    function automatic logic [31:0] rand_iw();
        logic [31:0] w;
        logic [6:0]  opcs [12];
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h0B};
        w        = $urandom;
        w[6:0]   = opcs[$urandom_range(0, 11)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        reset       = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        haz_wb_en   = '0;
        haz_wb_reg  = '0;
        haz_fwd_ok  = '0;
        haz_wb_data = '0;
        drive(1'b0, NOP, 32'h0);
        step();
        step();
        reset = 1'b1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_iw_out",    iw_out,             32'h00000013);
        chk("rst_wb_en",     {31'h0, wb_en_out}, 32'h0);
        chk("rst_imm",       imm_out,            32'h0);

        // ADDI x5,x0,7
        drive(1'b1, 32'h00700293, 32'h100);
        step();
        chk("addi_valid", {31'h0, out_valid},  32'h1);
        chk("addi_imm",   imm_out,             32'h7);
        chk("addi_rd",    {27'h0, wb_reg_out}, 32'h5);
        chk("addi_wben",  {31'h0, wb_en_out},  32'h1);

        // SW x2,8(x1)
        drive(1'b1, 32'h0020A423, 32'h104);
        step();
        chk("sw_wben", {31'h0, wb_en_out}, 32'h0);
        chk("sw_imm",  imm_out,            32'h8);

        // BEQ x0,x0,-4
        drive(1'b1, 32'hFE000EE3, 32'h108);
        step();
        chk("beq_imm",  imm_out,            32'hFFFFFFFC);
        chk("beq_wben", {31'h0, wb_en_out}, 32'h0);

        // ADD x3,x1,x2 against EX writing x1
        drive(1'b1, 32'h002081B3, 32'h10C);
        haz_wb_en  = 3'b001;
        haz_wb_reg = {5'd0, 5'd0, 5'd1};
        #1;
        chk("haz_stall", {31'h0, stall_out}, 32'h1);
        chk("haz_ready", {31'h0, in_ready},  32'h0);
        step();
        chk("haz_bubble", {31'h0, out_valid}, 32'h0);
        haz_wb_en = 3'b000;
        #1;
        chk("haz_clear_stall", {31'h0, stall_out}, 32'h0);
        step();
        chk("haz_cap_valid", {31'h0, out_valid}, 32'h1);
        chk("haz_cap_iw",    iw_out,             32'h002081B3);

`ifdef RV32I_ID_FORWARDING_EN
        drive(1'b1, 32'h002081B3, 32'h110);
        haz_wb_en   = 3'b001;
        haz_wb_reg  = {5'd0, 5'd0, 5'd1};
        haz_fwd_ok  = 3'b001;
        haz_wb_data = {32'h0, 32'h0, 32'hDEADBEEF};
        #1;
        chk("fwd_stall", {31'h0, stall_out}, 32'h0);
        step();
        chk("fwd_rs1", rs1_data_out, 32'hDEADBEEF);
        haz_wb_en  = 3'b000;
        haz_fwd_ok = 3'b000;
`endif

        // Flush while holding a bundle, incoming ADDI x7,x0,5 dropped
        out_ready = 1'b0;
        drive(1'b1, 32'h00500393, 32'h200);
        flush = 1'b1;
        #1;
        chk("flush_ready", {31'h0, in_ready}, 32'h1);
        step();
        chk("flush_valid", {31'h0, out_valid}, 32'h0);
        chk("flush_wben",  {31'h0, wb_en_out}, 32'h0);
        chk("flush_drop",  iw_out,             32'h002081B3);
        flush = 1'b0;
        drive(1'b0, NOP, 32'h0);
        step();
        chk("flush_idle", {31'h0, out_valid}, 32'h0);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, rand_iw(), $urandom);
            out_ready   = $urandom_range(0, 3) != 0;
            flush       = $urandom_range(0, 15) == 0;
            haz_wb_en   = 3'($urandom);
            haz_wb_reg  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3))};
            haz_fwd_ok  = 3'($urandom);
            haz_wb_data = {32'($urandom), 32'($urandom), 32'($urandom)};
            step();
        end

        // Asynchronous reset mid-stream with a valid bundle held
        flush     = 1'b0;
        haz_wb_en = 3'b000;
        out_ready = 1'b0;
        drive(1'b1, 32'h00700293, 32'h300);
        step();
        chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("async_rst_iw",    iw_out,             32'h00000013);
        chk("async_rst_wben",  {31'h0, wb_en_out}, 32'h0);
        step();
        reset = 1'b1;
        drive(1'b0, NOP, 32'h0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rv32i_id_stage
`default_nettype wire
